// File: rtl/axi_read_slave_if.sv
// AXI3 read-address and read-data channel bundle between a read master and the read slave.
interface axi_read_slave_if #(
  parameter int unsigned BusWidth  = 32,
  parameter int unsigned AddrWidth = 32
);
  logic [3:0]           ARID;
  logic [AddrWidth-1:0] ARADDR;
  logic [3:0]           ARLEN;
  logic [2:0]           ARSIZE;
  logic [1:0]           ARBURST;
  logic [1:0]           ARLOCK;
  logic [3:0]           ARCACHE;
  logic [2:0]           ARPROT;
  logic                 ARVALID;
  logic                 ARREADY;
  logic [3:0]           RID;
  logic [BusWidth-1:0]  RDATA;
  logic [1:0]           RRESP;
  logic                 RLAST;
  logic                 RVALID;
  logic                 RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_read_slave.sv
// AXI3 read responder: accepts one AR request and streams ARLEN+1 beats from a preloadable
// word memory, with FIXED/INCR/WRAP addressing and OKAY/SLVERR/DECERR responses.
module axi_read_slave #(
  parameter int unsigned BusWidth  = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned MemDepth  = 256
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  axi_read_slave_if.slave             bus,
  input  logic                        mem_we,
  input  logic [$clog2(MemDepth)-1:0] mem_waddr,
  input  logic [BusWidth-1:0]         mem_wdata
);
  localparam int unsigned ByteW     = BusWidth / 8;
  localparam int unsigned ByteShift = $clog2(ByteW);
  localparam int unsigned IdxW      = $clog2(MemDepth);

  typedef enum logic {IDLE, BURST} state_e;
  state_e state_q, state_d;

  logic [BusWidth-1:0]  mem [MemDepth];

  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [3:0]           len_q, len_d, cnt_q, cnt_d, rid_q, rid_d;
  logic [2:0]           size_q, size_d;
  logic [1:0]           burst_q, burst_d, rresp_q, rresp_d;
  logic                 slverr_q, slverr_d;
  logic                 arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [BusWidth-1:0]  rdata_q, rdata_d;

  logic                 ar_hs, r_hs, ar_err, beat_err, beat_oob;
  logic [AddrWidth-1:0] ar_bytes, bytes, wrap_mask, next_addr, beat_addr, beat_idx;
  logic [BusWidth-1:0]  beat_data;
  logic [1:0]           beat_resp;
  logic                 unused_sideband;

  assign unused_sideband = ^{bus.ARLOCK, bus.ARCACHE, bus.ARPROT};

  assign ar_hs = (state_q == IDLE) && bus.ARVALID && arready_q;
  assign r_hs  = rvalid_q && bus.RREADY;

  // Preload port; memory is deliberately outside the reset domain
  always_ff @(posedge ACLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Burst-wide error classification of the incoming request
  always_comb begin
    ar_bytes = AddrWidth'(1) << bus.ARSIZE;
    ar_err   = (32'(bus.ARSIZE) > ByteShift) || (bus.ARBURST == 2'b11) ||
               ((bus.ARBURST == 2'b10) &&
                (!(bus.ARLEN inside {4'd1, 4'd3, 4'd7, 4'd15}) ||
                 ((bus.ARADDR & (ar_bytes - AddrWidth'(1))) != '0)));
  end

  // Address of the beat after the one currently presented
  always_comb begin
    bytes     = AddrWidth'(1) << size_q;
    wrap_mask = ((AddrWidth'(len_q) + AddrWidth'(1)) * bytes) - AddrWidth'(1);
    unique case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + bytes) & wrap_mask);
      default: next_addr = addr_q + bytes;
    endcase
  end

  // Data and response for the beat being loaded this cycle
  always_comb begin
    beat_addr = (state_q == IDLE) ? bus.ARADDR : next_addr;
    beat_err  = (state_q == IDLE) ? ar_err : slverr_q;
    beat_idx  = beat_addr >> ByteShift;
    beat_oob  = (beat_idx >= AddrWidth'(MemDepth));
    beat_data = '0;
    beat_resp = 2'b00;
    if (beat_oob) begin
      beat_resp = 2'b11;
    end else if (beat_err) begin
      beat_resp = 2'b10;
    end else begin
      beat_data = mem[beat_idx[IdxW-1:0]];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ar_hs) state_d = BURST;
      BURST:   if (r_hs && rlast_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    rid_d     = rid_q;
    size_d    = size_q;
    burst_d   = burst_q;
    slverr_d  = slverr_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (ar_hs) begin
          addr_d    = bus.ARADDR;
          len_d     = bus.ARLEN;
          cnt_d     = 4'd0;
          rid_d     = bus.ARID;
          size_d    = bus.ARSIZE;
          burst_d   = bus.ARBURST;
          slverr_d  = ar_err;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = (bus.ARLEN == 4'd0);
          rdata_d   = beat_data;
          rresp_d   = beat_resp;
        end
      end
      BURST: begin
        if (r_hs && !rlast_q) begin
          cnt_d   = cnt_q + 4'd1;
          addr_d  = next_addr;
          rlast_d = ((cnt_q + 4'd1) == len_q);
          rdata_d = beat_data;
          rresp_d = beat_resp;
        end else if (r_hs) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      rid_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      slverr_q  <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      rid_q     <= rid_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      slverr_q  <= slverr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.ARREADY = arready_q;
  assign bus.RID     = rid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;
  assign bus.RLAST   = rlast_q;
  assign bus.RVALID  = rvalid_q;
endmodule
